// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, access size codes
// and the lane helpers used by both the store-side and load-side conversion.
`default_nettype none

package riscv_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE     = 2'd0,
        MEM_ACCESS   = 2'd1,
        MEM_COMPLETE = 2'd2
    } mem_state_t;

    localparam logic [2:0] SIZE_LB  = 3'b000;
    localparam logic [2:0] SIZE_LH  = 3'b001;
    localparam logic [2:0] SIZE_LW  = 3'b010;
    localparam logic [2:0] SIZE_LBU = 3'b100;
    localparam logic [2:0] SIZE_LHU = 3'b101;
    localparam logic [2:0] SIZE_SB  = 3'b000;
    localparam logic [2:0] SIZE_SH  = 3'b001;
    localparam logic [2:0] SIZE_SW  = 3'b010;

    // size_lo is ALUSelect[1:0]: 00 byte, 01 half, anything else word
    function automatic logic [3:0] byte_enable(input logic [1:0] size_lo,
                                               input logic [1:0] offset);
        case (size_lo)
            2'b00:   return 4'b0001 << offset;
            2'b01:   return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] size_lo,
                                        input logic [1:0] offset);
        case (size_lo)
            2'b00:   return 1'b1;
            2'b01:   return ~offset[0];
            default: return (offset == 2'b00);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/LoadConverter.sv
// Load-side lane select and sign/zero extension of a raw memory word.
`default_nettype none

module LoadConverter
    import riscv_pkg::*;
(
    input  logic [31:0] raw_data,
    input  logic [1:0]  byte_offset,
    input  logic [2:0]  size,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = raw_data[7:0];
        case (byte_offset)
            2'd0:    byte_lane = raw_data[7:0];
            2'd1:    byte_lane = raw_data[15:8];
            2'd2:    byte_lane = raw_data[23:16];
            default: byte_lane = raw_data[31:24];
        endcase
        half_lane = byte_offset[1] ? raw_data[31:16] : raw_data[15:0];
    end

    always_comb begin
        load_data = raw_data;
        case (size)
            SIZE_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
            SIZE_LBU: load_data = {24'h0, byte_lane};
            SIZE_LH:  load_data = {{16{half_lane[15]}}, half_lane};
            SIZE_LHU: load_data = {16'h0, half_lane};
            default:  load_data = raw_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_access_cycle.sv
// Memory pipeline stage: issues one request per aligned load/store, stalls the
// front of the pipe until acknowledged, and drives the memory-to-writeback register.
`default_nettype none

module memory_access_cycle
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] StoreCounterOutM,
    input  logic [5:0]  ALUSelectM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        RegWriteM,
    input  logic [4:0]  WriteAddressM,
    output logic        DMemReq,
    output logic        DMemWrite,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWriteData,
    output logic [3:0]  DMemByteEn,
    input  logic [31:0] DMemReadData,
    input  logic        DMemAck,
    output logic        StallM,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteAddressW,
    output logic        RegWriteW,
    output logic        MemReadW,
    output logic        MisalignedW
);

    mem_state_t state_q, state_d;

    logic        is_mem, aligned, valid_access, misaligned;
    logic [2:0]  size_q;
    logic [1:0]  offset_q;
    logic [31:0] alu_q;
    logic [4:0]  waddr_q;
    logic        regwrite_q;
    logic        load_q;
    logic [31:0] rdata_q;
    logic [31:0] converted;
    logic        unused_sel;

    // Upper select bits only matter to the ALU.
    assign unused_sel = ^ALUSelectM[5:3];

    assign is_mem       = MemReadM | MemWriteM;
    assign aligned      = is_aligned(ALUSelectM[1:0], ALUOutM[1:0]);
    assign valid_access = is_mem & aligned;
    assign misaligned   = is_mem & ~aligned;

    LoadConverter u_load_converter (
        .raw_data    (DMemReadData),
        .byte_offset (offset_q),
        .size        (size_q),
        .load_data   (converted)
    );

    always_comb begin
        state_d = state_q;
        StallM  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (valid_access) begin
                    StallM  = 1'b1;
                    state_d = MEM_ACCESS;
                end
            end
            MEM_ACCESS: begin
                StallM = 1'b1;
                if (DMemAck) begin
                    state_d = MEM_COMPLETE;
                end
            end
            MEM_COMPLETE: state_d = MEM_IDLE;
            default:      state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MEM_IDLE;
            DMemReq       <= 1'b0;
            DMemWrite     <= 1'b0;
            DMemAddr      <= 32'h0;
            DMemWriteData <= 32'h0;
            DMemByteEn    <= 4'b0000;
            size_q        <= 3'b000;
            offset_q      <= 2'b00;
            alu_q         <= 32'h0;
            waddr_q       <= 5'h0;
            regwrite_q    <= 1'b0;
            load_q        <= 1'b0;
            rdata_q       <= 32'h0;
            ReadDataW     <= 32'h0;
            ALUOutW       <= 32'h0;
            WriteAddressW <= 5'h0;
            RegWriteW     <= 1'b0;
            MemReadW      <= 1'b0;
            MisalignedW   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Writeback carries a bubble unless an instruction retires this edge.
            ReadDataW     <= 32'h0;
            ALUOutW       <= 32'h0;
            WriteAddressW <= 5'h0;
            RegWriteW     <= 1'b0;
            MemReadW      <= 1'b0;
            MisalignedW   <= 1'b0;
            case (state_q)
                MEM_IDLE: begin
                    if (valid_access) begin
                        DMemReq       <= 1'b1;
                        DMemWrite     <= MemWriteM;
                        DMemAddr      <= {ALUOutM[31:2], 2'b00};
                        DMemWriteData <= StoreCounterOutM;
                        DMemByteEn    <= byte_enable(ALUSelectM[1:0], ALUOutM[1:0]);
                        size_q        <= ALUSelectM[2:0];
                        offset_q      <= ALUOutM[1:0];
                        alu_q         <= ALUOutM;
                        waddr_q       <= WriteAddressM;
                        regwrite_q    <= RegWriteM & ~MemWriteM;
                        load_q        <= ~MemWriteM;
                    end else begin
                        ALUOutW       <= ALUOutM;
                        WriteAddressW <= WriteAddressM;
                        RegWriteW     <= RegWriteM & ~is_mem;
                        MisalignedW   <= misaligned;
                    end
                end
                MEM_ACCESS: begin
                    if (DMemAck) begin
                        DMemReq <= 1'b0;
                        rdata_q <= load_q ? converted : 32'h0;
                    end
                end
                MEM_COMPLETE: begin
                    ReadDataW     <= rdata_q;
                    ALUOutW       <= alu_q;
                    WriteAddressW <= waddr_q;
                    RegWriteW     <= regwrite_q;
                    MemReadW      <= load_q;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
